// File: rtl/matrix_loader_pkg.sv
// Shared types and constants for the matrix loader: FSM state encoding,
// default element width / matrix dimension and the RUN phase length.
package matrix_loader_pkg;

  localparam int BITS_AB_DEF = 8;
  localparam int DIM_DEF     = 8;
  localparam int RUN_CYCLES  = 3 * DIM_DEF - 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Systolic wavefront length for an arbitrary dimension.
  function automatic int run_cycles(input int dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/matrix_loader_row_unpack.sv
// Combinational unpacking of one packed input row into an array of
// signed elements; element i sits at row[i*BITS_AB +: BITS_AB].
module row_unpack
  import matrix_loader_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEF,
  parameter int DIM     = DIM_DEF
) (
  input  logic        [DIM*BITS_AB-1:0] row,
  output logic signed [BITS_AB-1:0]     elems [DIM]
);

  for (genvar i = 0; i < DIM; i++) begin : g_elem
    assign elems[i] = row[i*BITS_AB +: BITS_AB];
  end

endmodule

// File: rtl/matrix_loader.sv
// Streams DIM rows of A then DIM rows of B into the operand memories, then
// enables the array for 3*DIM-2 cycles. Optional stall counter: MATRIX_LOADER_STALL_CNT_EN.
module matrix_loader
  import matrix_loader_pkg::*;
#(
  parameter  int BITS_AB = BITS_AB_DEF,
  parameter  int DIM     = DIM_DEF,
  localparam int ROWBITS = $clog2(DIM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIM*BITS_AB-1:0]    in_data,
  output logic                      WrEnA,
  output logic [ROWBITS-1:0]        Arow,
  output logic signed [BITS_AB-1:0] Ain [DIM],
  output logic                      WrEnB,
  output logic [ROWBITS-1:0]        Brow,
  output logic signed [BITS_AB-1:0] Bin [DIM],
  output logic                      en,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               stall_cnt
);

  localparam int RUN_N = run_cycles(DIM);
  localparam int RUN_W = $clog2(RUN_N + 2);

  state_t                    state, state_nxt;
  logic [ROWBITS-1:0]        row_cnt;
  logic [RUN_W-1:0]          run_cnt;
  logic                      accept, last_row;
  logic signed [BITS_AB-1:0] a_row_p0 [DIM];
  logic signed [BITS_AB-1:0] b_row_p0 [DIM];

  row_unpack #(.BITS_AB(BITS_AB), .DIM(DIM)) u_unpack_a (.row(in_data), .elems(a_row_p0));
  row_unpack #(.BITS_AB(BITS_AB), .DIM(DIM)) u_unpack_b (.row(in_data), .elems(b_row_p0));

  assign in_ready = (state == LOAD_A) || (state == LOAD_B);
  assign accept   = in_valid && in_ready;
  assign last_row = (row_cnt == ROWBITS'(DIM - 1));
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  // RUN's first cycle overlaps the final B write, so en starts one cycle later.
  assign en       = (state == RUN) && (run_cnt != '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD_A;
      LOAD_A:  if (accept && last_row) state_nxt = LOAD_B;
      LOAD_B:  if (accept && last_row) state_nxt = RUN;
      RUN:     if (run_cnt == RUN_W'(RUN_N)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      row_cnt <= '0;
      run_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (abort)       row_cnt <= '0;
      else if (accept) row_cnt <= last_row ? '0 : row_cnt + 1'b1;
      run_cnt <= (state == RUN && state_nxt == RUN) ? run_cnt + 1'b1 : '0;
    end
  end

  // ---- p1: registered memory write port, one cycle after acceptance ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WrEnA <= 1'b0;
      WrEnB <= 1'b0;
      Arow  <= '0;
      Brow  <= '0;
      for (int i = 0; i < DIM; i++) begin
        Ain[i] <= '0;
        Bin[i] <= '0;
      end
    end else begin
      WrEnA <= accept && !abort && (state == LOAD_A);
      WrEnB <= accept && !abort && (state == LOAD_B);
      Arow  <= abort ? '0 : row_cnt;
      Brow  <= abort ? '0 : row_cnt;
      if (accept && !abort && state == LOAD_A) Ain <= a_row_p0;
      if (accept && !abort && state == LOAD_B) Bin <= b_row_p0;
    end
  end

`ifdef MATRIX_LOADER_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (state == IDLE && state_nxt == LOAD_A) begin
      stall_q <= '0;
    end else if (in_ready && !in_valid && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: reset, streaming, bubbles, start during
// RUN, abort on acceptance and reset during RUN.
module tb_matrix_loader;

  localparam int BITS_AB = 8;
  localparam int DIM     = 8;

  logic                      clk = 1'b0;
  logic                      rst_n, start, abort, in_valid, in_ready;
  logic [DIM*BITS_AB-1:0]    in_data;
  logic                      WrEnA, WrEnB, en, busy, done;
  logic [2:0]                Arow, Brow;
  logic signed [BITS_AB-1:0] Ain [DIM];
  logic signed [BITS_AB-1:0] Bin [DIM];
  logic [15:0]               stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  int wa_row [16], wa_cyc [16], wb_row [16], wb_cyc [16];
  int n_wa, n_wb, data_err, en_cnt, en_runs, en_first, done_cnt, collide;
  int first_a3;

  matrix_loader #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .WrEnA(WrEnA), .Arow(Arow), .Ain(Ain),
    .WrEnB(WrEnB), .Brow(Brow), .Bin(Bin),
    .en(en), .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DIM*BITS_AB-1:0] row_word(input int r);
    logic [DIM*BITS_AB-1:0] w;
    for (int i = 0; i < DIM; i++) w[i*BITS_AB +: BITS_AB] = 8'(r * 8 + i);
    return w;
  endfunction

  // Runs one job from start; observes at each falling edge, then drives.
  task automatic run_job(input bit bubbles, input bit poke_start, input int rst_at_en);
    int  row_idx;
    bit  phase, en_prev, finished;
    n_wa = 0; n_wb = 0; data_err = 0; en_cnt = 0; en_runs = 0; en_first = -1;
    done_cnt = 0; collide = 0; first_a3 = -1;
    row_idx = 0; phase = 0; en_prev = 0; finished = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 300 && !finished; k++) begin
      if (WrEnA) begin
        if (n_wa < 16) begin wa_row[n_wa] = int'(Arow); wa_cyc[n_wa] = k; end
        if (n_wa == 0) first_a3 = int'($unsigned(Ain[3]));
        n_wa++;
        for (int i = 0; i < DIM; i++) if (Ain[i] !== 8'(Arow * 8 + i)) data_err++;
      end
      if (WrEnB) begin
        if (n_wb < 16) begin wb_row[n_wb] = int'(Brow); wb_cyc[n_wb] = k; end
        n_wb++;
        for (int i = 0; i < DIM; i++) if (Bin[i] !== 8'((8 + Brow) * 8 + i)) data_err++;
      end
      if (en) begin
        if (en_cnt == 0) en_first = k;
        if (!en_prev) en_runs++;
        en_cnt++;
      end
      en_prev = en;
      if (en && (WrEnA || WrEnB)) collide++;
      if (done) done_cnt++;
      if (done_cnt > 0 && !busy) finished = 1;
      if (rst_at_en != 0 && en && en_cnt == rst_at_en) begin
        rst_n = 1'b0; in_valid = 1'b0; start = 1'b0;
        #1;
        chk("rst_run_en", en, 0);
        chk("rst_run_busy", busy, 0);
        return;
      end
      start = poke_start && en && (en_cnt == 5);
      if (in_ready && row_idx < 16) begin
        in_valid = bubbles ? !phase : 1'b1;
        phase    = !phase;
        in_data  = row_word(row_idx);
      end else begin
        in_valid = 1'b0;
      end
      if (in_ready && in_valid) row_idx++;
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0;
    if (!finished) chk("job_timeout", 0, 1);
  endtask

  task automatic chk_order(input string tag);
    int err = 0;
    for (int k = 0; k < 8; k++) begin
      if (wa_row[k] != k) err++;
      if (wb_row[k] != k) err++;
    end
    chk({tag, "_row_order"}, err, 0);
    chk({tag, "_a_writes"}, n_wa, 8);
    chk({tag, "_b_writes"}, n_wb, 8);
    chk({tag, "_data"}, data_err, 0);
  endtask

  initial begin
    logic [7:0] ain_or, bin_or;
    int         exp_stall, late_done;
    rst_n = 1'b0; start = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    ain_or = '0; bin_or = '0;
    for (int i = 0; i < DIM; i++) begin ain_or |= Ain[i]; bin_or |= Bin[i]; end
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wren", {WrEnA, WrEnB}, 0);
    chk("rst_rows", {Arow, Brow}, 0);
    chk("rst_data", {ain_or, bin_or}, 0);
    chk("rst_en_done", {en, done}, 0);
    chk("rst_stall", stall_cnt, 0);
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Back-to-back rows
    run_job(0, 0, 0);
    chk_order("stream");
    chk("stream_ain3_row0", first_a3, 3);
    chk("stream_consecutive", wb_cyc[7] - wa_cyc[0], 15);
    chk("stream_en_cycles", en_cnt, 22);
    chk("stream_en_runs", en_runs, 1);
    chk("stream_en_first", en_first, wb_cyc[7] + 1);
    chk("stream_collide", collide, 0);
    chk("stream_done", done_cnt, 1);
    chk("stream_stall", stall_cnt, 0);
    chk("hold_ain3", $unsigned(Ain[3]), 59);
    chk("hold_bin0", $unsigned(Bin[0]), 120);

    // Bubble every other load cycle
    run_job(1, 0, 0);
    chk_order("bubble");
`ifdef MATRIX_LOADER_STALL_CNT_EN
    exp_stall = 15;
`else
    exp_stall = 0;
`endif
    chk("bubble_stall", stall_cnt, exp_stall);
    chk("bubble_en_cycles", en_cnt, 22);
    chk("bubble_done", done_cnt, 1);

    // start during RUN is ignored
    run_job(0, 1, 0);
    chk("runstart_en_cycles", en_cnt, 22);
    chk("runstart_en_runs", en_runs, 1);
    chk("runstart_done", done_cnt, 1);
    @(negedge clk);
    chk("runstart_no_rejob", busy, 0);

    // abort together with acceptance of A row 4
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      in_valid = 1'b1; in_data = row_word(r);
      @(negedge clk);
    end
    chk("abort_pre_arow", Arow, 3);
    in_valid = 1'b1; in_data = row_word(4); abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_no_write", WrEnA, 0);
    chk("abort_idle", busy, 0);
    chk("abort_arow", Arow, 0);
    late_done = 0;
    repeat (5) begin
      if (done || en) late_done++;
      @(negedge clk);
    end
    chk("abort_no_done", late_done, 0);
    run_job(0, 0, 0);
    chk("abort_restart_arow0", wa_row[0], 0);
    chk_order("restart");
    chk("restart_done", done_cnt, 1);

    // reset during RUN cycle 10
    run_job(0, 0, 10);
    @(negedge clk);
    rst_n = 1'b1;
    late_done = 0;
    repeat (30) begin
      if (done || en || busy) late_done++;
      @(negedge clk);
    end
    chk("rst_run_no_done", late_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
